// File: rtl/qmult_pipe_if.sv
// rtl/qmult_pipe_if.sv - operand/result handshake bundle for qmult_pipe
interface qmult_pipe_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 1
);
   logic                          valid_i;
   logic                          ready_o;
   logic [LANES*DATA_WIDTH-1:0]   input1_i;
   logic [LANES*DATA_WIDTH-1:0]   input2_i;
   logic [1:0]                    round_mode_i;
   logic                          valid_o;
   logic                          ready_i;
   logic [LANES*DATA_WIDTH-1:0]   result_o;
   logic [LANES-1:0]              overflow_o;

   modport slave (
      input  valid_i, input1_i, input2_i, round_mode_i, ready_i,
      output ready_o, valid_o, result_o, overflow_o
   );

   modport master (
      output valid_i, input1_i, input2_i, round_mode_i, ready_i,
      input  ready_o, valid_o, result_o, overflow_o
   );
endinterface

// File: rtl/qmult_pipe.sv
// rtl/qmult_pipe.sv - pipelined multi-lane signed fixed-point multiplier
// Stage 1 registers raw products; rounding/saturation feeds the result stages.
module qmult_pipe #(
   parameter int INTEGER_BITS    = 8,
   parameter int FRACTIONAL_BITS = 24,
   parameter int LANES           = 1,
   parameter int STAGES          = 2,
   parameter int SATURATE        = 1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   qmult_pipe_if.slave    bus
);
   localparam int DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS;
   localparam int PW         = 2 * DATA_WIDTH;
   localparam int RD         = (STAGES > 1) ? STAGES - 1 : 1;
   localparam logic [PW-1:0] OFFSET    = PW'(1) << (FRACTIONAL_BITS - 1);
   localparam logic [PW-1:0] OFFSET_M1 = OFFSET - PW'(1);
   localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic                          advance;
   logic [LANES*PW-1:0]           prod_d;
   logic [LANES*PW-1:0]           fin_prod;
   logic [1:0]                    fin_mode;
   logic                          fin_vld;
   logic [LANES*DATA_WIDTH-1:0]   fin_res;
   logic [LANES-1:0]              fin_ovf;

   logic [LANES*DATA_WIDTH-1:0]   res_q [RD];
   logic [LANES-1:0]              ovf_q [RD];
   logic [RD-1:0]                 vld_r;

   // One global stall: every stage moves together, so order and bubbles are kept.
   assign advance     = !bus.valid_o || bus.ready_i;
   assign bus.ready_o = advance;

   if (STAGES > 1) begin : g_prod
      logic [LANES*PW-1:0] prod_q;
      logic [1:0]          mode_q;
      logic                vld_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            prod_q <= '0;
            mode_q <= '0;
            vld_q  <= 1'b0;
         end else if (advance) begin
            prod_q <= prod_d;
            mode_q <= bus.round_mode_i;
            vld_q  <= bus.valid_i;
         end
      end

      assign fin_prod = prod_q;
      assign fin_mode = mode_q;
      assign fin_vld  = vld_q;
   end else begin : g_direct
      assign fin_prod = prod_d;
      assign fin_mode = bus.round_mode_i;
      assign fin_vld  = bus.valid_i;
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic signed [DATA_WIDTH-1:0] a;
      logic signed [DATA_WIDTH-1:0] b;
      logic signed [PW-1:0]         prod;
      logic [PW-1:0]                fp;
      logic [PW-1:0]                addend;
      logic [PW-1:0]                rnd;
      logic [INTEGER_BITS:0]        top;
      logic                         ovf;
      logic [DATA_WIDTH-1:0]        sliced;
      logic                         unused_lsb;

      assign a    = bus.input1_i[k*DATA_WIDTH +: DATA_WIDTH];
      assign b    = bus.input2_i[k*DATA_WIDTH +: DATA_WIDTH];
      // Sign-extend before multiplying so -2^(IB-1) squared stays exact.
      assign prod = PW'(a) * PW'(b);
      assign prod_d[k*PW +: PW] = prod;
      assign fp   = fin_prod[k*PW +: PW];

      always_comb begin
         addend = OFFSET;
         case (fin_mode)
            2'b00:   addend = '0;
            2'b10:   addend = OFFSET_M1 + {{(PW-1){1'b0}}, fp[FRACTIONAL_BITS]};
            default: addend = OFFSET;
         endcase
      end

      assign rnd        = fp + addend;
      assign top        = rnd[PW-1 -: INTEGER_BITS+1];
      assign ovf        = (top != '0) && (top != '1);
      assign sliced     = rnd[DATA_WIDTH+FRACTIONAL_BITS-1 : FRACTIONAL_BITS];
      assign unused_lsb = ^rnd[FRACTIONAL_BITS-1:0];

      assign fin_ovf[k] = ovf;
      assign fin_res[k*DATA_WIDTH +: DATA_WIDTH] =
         ((SATURATE != 0) && ovf) ? (rnd[PW-1] ? MIN_NEG : MAX_POS) : sliced;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < RD; i++) begin
            res_q[i] <= '0;
            ovf_q[i] <= '0;
         end
         vld_r <= '0;
      end else if (advance) begin
         res_q[0] <= fin_res;
         ovf_q[0] <= fin_ovf;
         vld_r[0] <= fin_vld;
         for (int i = 1; i < RD; i++) begin
            res_q[i] <= res_q[i-1];
            ovf_q[i] <= ovf_q[i-1];
            vld_r[i] <= vld_r[i-1];
         end
      end
   end

   assign bus.valid_o    = vld_r[RD-1];
   assign bus.result_o   = res_q[RD-1];
   assign bus.overflow_o = ovf_q[RD-1];
endmodule

// File: tb/tb_qmult_pipe.sv
// tb/tb_qmult_pipe.sv - self-checking bench for qmult_pipe (Q8.24)
module tb_qmult_pipe;
   typedef struct packed {
      logic [127:0] res;
      logic [3:0]   ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   qmult_pipe_if #(.DATA_WIDTH(32), .LANES(1)) ifa ();
   qmult_pipe_if #(.DATA_WIDTH(32), .LANES(1)) ifw ();
   qmult_pipe_if #(.DATA_WIDTH(32), .LANES(4)) ifm ();

   qmult_pipe dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
   qmult_pipe #(.SATURATE(0)) dut_w (.clk_i(clk), .rst_i(rst), .bus(ifw));
   qmult_pipe #(.LANES(4), .STAGES(3)) dut_m (.clk_i(clk), .rst_i(rst), .bus(ifm));

   int           total = 0;
   int           bad = 0;
   int           cur = 0;
   int           delivered = 0;
   exp_t         expq [$];
   bit           held = 1'b0;
   bit           last_acc;
   logic [127:0] p_res;
   logic [3:0]   p_ovf;
   bit           s_vo;
   logic [127:0] s_res;
   logic [3:0]   s_ovf;
   logic [31:0]  specials [6] = '{32'h80000000, 32'h7FFFFFFF, 32'h00800000,
                                  32'hFFFFFFFF, 32'h01000000, 32'h00000000};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Floor, then bump by the discarded remainder according to the rounding rule.
   function automatic logic [31:0] ref_lane(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] m, input bit sat, output bit ov);
      longint p, q, r, h;
      h = longint'(1) <<< 23;
      p = longint'($signed(a)) * longint'($signed(b));
      q = p >>> 24;
      r = p - q * 64'sd16777216;
      if (m == 2'b10) begin
         if (r > h || (r == h && q[0])) q = q + 1;
      end else if (m != 2'b00) begin
         if (r >= h) q = q + 1;
      end
      ov = (q > 64'sd2147483647) || (q < -64'sd2147483648);
      if (ov && sat) return (q > 0) ? 32'h7FFFFFFF : 32'h80000000;
      return q[31:0];
   endfunction

   function automatic exp_t model(input logic [127:0] a, input logic [127:0] b, input logic [1:0] m);
      exp_t e;
      bit   ov;
      int   n;
      e = '0;
      n = (cur == 2) ? 4 : 1;
      for (int k = 0; k < n; k++) begin
         e.res[k*32 +: 32] = ref_lane(a[k*32 +: 32], b[k*32 +: 32], m, cur != 1, ov);
         e.ovf[k] = ov;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: return r;
         1: return 32'($signed(r) >>> 6);
         2: return {{20{r[11]}}, r[11:0]};
         default: return specials[$urandom_range(0, 5)];
      endcase
   endfunction

   function automatic logic [127:0] rand_bus();
      logic [127:0] v;
      for (int k = 0; k < 4; k++) v[k*32 +: 32] = rand_op();
      return v;
   endfunction

   task automatic drive(input bit vi, input logic [127:0] a, input logic [127:0] b,
                        input logic [1:0] m, input bit ri);
      ifa.valid_i = 1'b0; ifa.input1_i = '0; ifa.input2_i = '0; ifa.round_mode_i = '0; ifa.ready_i = 1'b1;
      ifw.valid_i = 1'b0; ifw.input1_i = '0; ifw.input2_i = '0; ifw.round_mode_i = '0; ifw.ready_i = 1'b1;
      ifm.valid_i = 1'b0; ifm.input1_i = '0; ifm.input2_i = '0; ifm.round_mode_i = '0; ifm.ready_i = 1'b1;
      case (cur)
         0: begin ifa.valid_i = vi; ifa.input1_i = a[31:0]; ifa.input2_i = b[31:0];
                  ifa.round_mode_i = m; ifa.ready_i = ri; end
         1: begin ifw.valid_i = vi; ifw.input1_i = a[31:0]; ifw.input2_i = b[31:0];
                  ifw.round_mode_i = m; ifw.ready_i = ri; end
         default: begin ifm.valid_i = vi; ifm.input1_i = a; ifm.input2_i = b;
                  ifm.round_mode_i = m; ifm.ready_i = ri; end
      endcase
   endtask

   task automatic sample();
      case (cur)
         0: begin s_vo = ifa.valid_o; s_res = 128'(ifa.result_o); s_ovf = 4'(ifa.overflow_o); end
         1: begin s_vo = ifw.valid_o; s_res = 128'(ifw.result_o); s_ovf = 4'(ifw.overflow_o); end
         default: begin s_vo = ifm.valid_o; s_res = ifm.result_o; s_ovf = ifm.overflow_o; end
      endcase
   endtask

   function automatic bit get_ready();
      case (cur)
         0: return ifa.ready_o;
         1: return ifw.ready_o;
         default: return ifm.ready_o;
      endcase
   endfunction

   // One clock: check outputs at the falling edge, then drive the next inputs.
   task automatic cyc(input bit vi, input logic [127:0] a, input logic [127:0] b,
                      input logic [1:0] m, input bit ri);
      bit   ro;
      exp_t e;
      @(negedge clk);
      sample();
      if (held) begin
         chk("hold_valid", 128'(s_vo), 128'(1));
         chk("hold_result", s_res, p_res);
         chk("hold_ovf", 128'(s_ovf), 128'(p_ovf));
      end
      if (s_vo && ri) begin
         total++;
         assert (expq.size() != 0) else begin
            bad++;
            $error("FAIL spurious_result observed=valid expected=no pending result");
         end
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("result", s_res, e.res);
            chk("overflow", 128'(s_ovf), 128'(e.ovf));
            delivered++;
         end
      end
      held  = s_vo && !ri;
      p_res = s_res;
      p_ovf = s_ovf;
      drive(vi, a, b, m, ri);
      #1;
      ro = get_ready();
      chk("ready", 128'(ro), 128'(!s_vo || ri));
      last_acc = vi && ro;
      if (last_acc) expq.push_back(model(a, b, m));
   endtask

   task automatic directed(input string tag, input logic [127:0] a, input logic [127:0] b,
                           input logic [1:0] m, input logic [127:0] er, input logic [3:0] eo,
                           input int lat);
      int n;
      n = 0;
      cyc(1'b1, a, b, m, 1'b1);
      do begin
         cyc(1'b0, '0, '0, 2'b00, 1'b1);
         n++;
      end while (!s_vo && n < 8);
      chk({tag, "_latency"}, 128'(n), 128'(lat));
      chk({tag, "_res"}, s_res, er);
      chk({tag, "_ovf"}, 128'(s_ovf), 128'(eo));
   endtask

   task automatic rand_stream(input int cycles, input int pv, input int pr);
      for (int i = 0; i < cycles; i++)
         cyc($urandom_range(0, 99) < pv, rand_bus(), rand_bus(), 2'($urandom_range(0, 3)),
             $urandom_range(0, 99) < pr);
   endtask

   task automatic drain(input string tag);
      repeat (10) cyc(1'b0, '0, '0, 2'b00, 1'b1);
      chk(tag, 128'(expq.size()), 128'(0));
   endtask

   initial begin
      logic [127:0] a, b;
      int           sent, accs;
      rst = 1'b1;
      drive(1'b0, '0, '0, 2'b00, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid_a", 128'(ifa.valid_o), 128'(0));
      chk("rst_result_a", 128'(ifa.result_o), 128'(0));
      chk("rst_ovf_a", 128'(ifa.overflow_o), 128'(0));
      chk("rst_valid_m", 128'(ifm.valid_o), 128'(0));
      chk("rst_result_m", ifm.result_o, 128'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready_a", 128'(ifa.ready_o), 128'(1));
      chk("post_rst_ready_w", 128'(ifw.ready_o), 128'(1));

      cur = 0;
      directed("basic", 128'h01800000, 128'h02000000, 2'b01, 128'h03000000, 4'h0, 2);
      directed("r1_trunc", 128'h00000001, 128'h00800000, 2'b00, 128'h00000000, 4'h0, 2);
      directed("r1_up",    128'h00000001, 128'h00800000, 2'b01, 128'h00000001, 4'h0, 2);
      directed("r1_even",  128'h00000001, 128'h00800000, 2'b10, 128'h00000000, 4'h0, 2);
      directed("r3_trunc", 128'h00000003, 128'h00800000, 2'b00, 128'h00000001, 4'h0, 2);
      directed("r3_up",    128'h00000003, 128'h00800000, 2'b01, 128'h00000002, 4'h0, 2);
      directed("r3_even",  128'h00000003, 128'h00800000, 2'b10, 128'h00000002, 4'h0, 2);
      directed("r3_mode3", 128'h00000003, 128'h00800000, 2'b11, 128'h00000002, 4'h0, 2);
      directed("rn_trunc", 128'hFFFFFFFF, 128'h00800000, 2'b00, 128'hFFFFFFFF, 4'h0, 2);
      directed("rn_up",    128'hFFFFFFFF, 128'h00800000, 2'b01, 128'h00000000, 4'h0, 2);
      directed("sat_pos",  128'h7F000000, 128'h02000000, 2'b01, 128'h7FFFFFFF, 4'h1, 2);
      directed("sat_min2", 128'h80000000, 128'h80000000, 2'b01, 128'h7FFFFFFF, 4'h1, 2);
      directed("sat_neg",  128'h7F000000, 128'hFE000000, 2'b01, 128'h80000000, 4'h1, 2);

      // Five back-to-back operands with ready_i dropped for three cycles.
      delivered = 0;
      sent = 0;
      a = rand_bus();
      b = rand_bus();
      for (int c = 0; c < 20 && sent < 5; c++) begin
         cyc(1'b1, a, b, 2'($urandom_range(0, 3)), !(c >= 3 && c < 6));
         if (last_acc) begin
            sent++;
            a = rand_bus();
            b = rand_bus();
         end
      end
      drain("bp_drain");
      chk("bp_delivered", 128'(delivered), 128'(5));

      accs = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, rand_bus(), rand_bus(), 2'b10, 1'b1);
         if (last_acc) accs++;
      end
      chk("throughput", 128'(accs), 128'(10));
      drain("tp_drain");

      rand_stream(200, 75, 70);
      drain("rand_a_drain");

      // Reset with two transactions in flight and the output stalled.
      cyc(1'b1, rand_bus(), rand_bus(), 2'b01, 1'b1);
      cyc(1'b1, rand_bus(), rand_bus(), 2'b01, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, '0, '0, 2'b00, 1'b0);
      @(negedge clk);
      chk("midrst_valid", 128'(ifa.valid_o), 128'(0));
      chk("midrst_result", 128'(ifa.result_o), 128'(0));
      rst = 1'b0;
      expq.delete();
      held = 1'b0;
      delivered = 0;
      repeat (6) cyc(1'b0, '0, '0, 2'b00, 1'b1);
      chk("midrst_no_stale", 128'(delivered), 128'(0));

      cur = 1;
      directed("wrap", 128'h7F000000, 128'h02000000, 2'b01, 128'hFE000000, 4'h1, 2);
      rand_stream(100, 75, 70);
      drain("rand_w_drain");

      cur = 2;
      directed("lanes",
               {32'h00000003, 32'h7F000000, 32'hFFFFFFFF, 32'h01800000},
               {32'h00800000, 32'h02000000, 32'h00800000, 32'h02000000}, 2'b01,
               {32'h00000002, 32'h7FFFFFFF, 32'h00000000, 32'h03000000}, 4'b0100, 3);
      rand_stream(100, 75, 70);
      drain("rand_m_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=no finish expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/qmult_pipe.md
QMULT_PIPE -- requirements
Module: qmult_pipe

Interface
REQ-001 SHALL have parameter INTEGER_BITS, default 8, meaning integer bits per operand, sign included.
REQ-002 SHALL have parameter FRACTIONAL_BITS, default 24, meaning fractional bits per operand; DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS.
REQ-003 SHALL have parameter LANES, default 1, meaning independent multiplier lanes sharing one handshake.
REQ-004 SHALL have parameter STAGES, default 2, meaning pipeline depth (legal range 1..4).
REQ-005 SHALL have parameter SATURATE, default 1, meaning 1 = clamp on overflow, 0 = wrap.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-008 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-009 SHALL have port valid_i  input  1  operands valid.
REQ-010 SHALL have port ready_o  output  1  block accepts operands this cycle.
REQ-011 SHALL have port input1_i  input  LANES*DATA_WIDTH  signed operand A, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port input2_i  input  LANES*DATA_WIDTH  signed operand B, same packing.
REQ-013 SHALL have port round_mode_i  input  2  00 truncate (floor), 01 round-half-up, 10 round-half-even, 11 treated as 01.
REQ-014 SHALL have port valid_o  output  1  result valid.
REQ-015 SHALL have port ready_i  input  1  downstream accepts result.
REQ-016 SHALL have port result_o  output  LANES*DATA_WIDTH  signed Q(INTEGER_BITS).(FRACTIONAL_BITS) products, same packing.
REQ-017 SHALL have port overflow_o  output  LANES  per-lane overflow flag, qualified by valid_o.

Function
REQ-018 SHALL compute per lane the full 2*DATA_WIDTH signed product, apply rounding, then take bits [DATA_WIDTH+FRACTIONAL_BITS-1 : FRACTIONAL_BITS].
REQ-019 Rounding, with OFFSET = 2^(FRACTIONAL_BITS-1): truncate adds 0; half-up adds OFFSET; half-even adds OFFSET-1 plus product bit FRACTIONAL_BITS.
REQ-020 Rounding addition SHALL be done at 2*DATA_WIDTH width; no intermediate overflow is permitted.
REQ-021 Overflow SHALL be set when rounded bits [2*DATA_WIDTH-1 : DATA_WIDTH+FRACTIONAL_BITS-1] are not all equal.
REQ-022 With SATURATE=1 and overflow, result SHALL be max positive (0x7FFF..F) if the rounded sign is 0, else min negative (0x800..0); with SATURATE=0, the sliced bits SHALL pass unchanged; overflow_o is set in both cases.
REQ-023 round_mode_i SHALL be sampled with the operands on acceptance and travel with that transaction.
REQ-024 Acceptance SHALL occur on a cycle with valid_i && ready_o; the result SHALL appear on valid_o exactly STAGES cycles later when no stall occurs.
REQ-025 The pipeline SHALL advance when !valid_o || ready_i; ready_o SHALL equal that advance term (combinational from ready_i and valid_o only).
REQ-026 While valid_o && !ready_i, result_o, overflow_o and valid_o SHALL hold stable and no internal stage SHALL change.
REQ-027 Full throughput: one transaction per cycle SHALL be sustained while ready_i is held high.
REQ-028 Bubbles (valid_i low on an advance cycle) SHALL propagate as invalid stages; the transaction order SHALL be preserved.
REQ-029 Lanes SHALL be fully independent arithmetically; one lane's overflow SHALL not affect another lane.
REQ-030 A result SHALL be exact for operand -2^(INTEGER_BITS-1) in both inputs, i.e. it saturates, with no sign corruption.

Reset
REQ-031 On rst_i high at a clock edge, all stage valid bits, valid_o, result_o and overflow_o SHALL be 0 on the next cycle.
REQ-032 Reset mid-operation SHALL discard all in-flight transactions; no stale valid_o after release.
REQ-033 ready_o SHALL be 1 in the first cycle after reset release (valid_o = 0).

Verification (Q8.24, LANES=1, STAGES=2, SATURATE=1 unless stated)
REQ-034 Basic: 0x01800000 * 0x02000000, mode 01 -> result 0x03000000, overflow 0, valid_o two cycles after acceptance.
REQ-035 Rounding: 0x00000001 * 0x00800000 -> trunc 0x00000000, half-up 0x00000001, half-even 0x00000000; 0x00000003 * 0x00800000 -> trunc 0x00000001, half-up 0x00000002, half-even 0x00000002; 0xFFFFFFFF * 0x00800000 -> trunc 0xFFFFFFFF, half-up 0x00000000.
REQ-036 Saturation: 0x7F000000 * 0x02000000 -> 0x7FFFFFFF, overflow 1; 0x80000000 * 0x80000000 -> 0x7FFFFFFF, overflow 1; 0x7F000000 * 0xFE000000 -> 0x80000000, overflow 1; with SATURATE=0, the first case -> 0xFE000000, overflow 1.
REQ-037 Backpressure: stream 5 back-to-back transactions, ready_i low for 3 cycles mid-stream -> outputs held stable while stalled, all 5 results delivered in order, none lost or duplicated.
REQ-038 Multi-lane: LANES=4, lane 2 overflows, others nominal -> only overflow_o[2] set, other lanes correct.
REQ-039 Reset mid-stream: assert rst_i with 2 transactions in flight -> valid_o 0 next cycle, no result from them ever appears.
